// File: rtl/ssid_hit_generator_if.sv
// Output stream of the SSID/hit generator: one item (SSID + hitInfo)
// qualified by newAddress, accepted by the sink with ready.
interface ssid_hit_generator_if #(
  parameter int SSIDBITS  = 8,
  parameter int NCOLS_HLM = 16
);
  logic [SSIDBITS-1:0]  SSID;
  logic [NCOLS_HLM-1:0] hitInfo;
  logic                 newAddress;
  logic                 ready;

  modport master (output SSID, output hitInfo, output newAddress, input ready);
  modport slave  (input SSID, input hitInfo, input newAddress, output ready);
endinterface

// File: rtl/ssid_hit_generator.sv
// SSID/hit word source for the hit-list and hit-count memories.
// Mode 0 sweeps SSID 0..NROWS_HCM-1; mode 1 plays back a runtime-loaded table.
// The item registers are loaded one entry ahead, so a held-high ready
// yields one item per clock.
module ssid_hit_generator #(
  parameter int SSIDBITS   = 8,
  parameter int NCOLS_HLM  = 16,
  parameter int NROWS_HCM  = 256,
  parameter int TABLEDEPTH = 32,
  parameter int IDXBITS    = $clog2(TABLEDEPTH),
  parameter int LENBITS    = $clog2(TABLEDEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                stop,
  input  logic                mode,
  input  logic                loopForever,
  input  logic [LENBITS-1:0]  numEntries,
  input  logic                tableWrEn,
  input  logic [IDXBITS-1:0]  tableWrAddr,
  input  logic [SSIDBITS-1:0] tableWrData,
  output logic                busy,
  output logic                done,
  ssid_hit_generator_if.master hitBus
);

  localparam int PASSW = NCOLS_HLM - SSIDBITS;
  // index must hold both a sweep SSID and a table length
  localparam int CNTW  = (SSIDBITS > LENBITS) ? SSIDBITS : LENBITS;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t              state, nextState;
  logic [SSIDBITS-1:0] tbl [TABLEDEPTH];
  logic [CNTW-1:0]     index, lastIdx, nextIdx;
  logic [PASSW-1:0]    passCnt, nextPass;
  logic [LENBITS-1:0]  numR, numClamp;
  logic                modeR, loopR, stopReq;
  logic [SSIDBITS-1:0] ssidR, nextSsid, firstSsid;
  logic [NCOLS_HLM-1:0] hitR;
  logic                xfer, isLast, finishNow, emptyStart;

  // Playback table: written only outside RUN, never reset
  always_ff @(posedge clock) begin
    if (tableWrEn && state != RUN && {1'b0, tableWrAddr} < (IDXBITS + 1)'(TABLEDEPTH))
      tbl[tableWrAddr] <= tableWrData;
  end

  // Item sequencing: last-entry detect, next index/pass and next item value
  always_comb begin
    xfer       = (state == RUN) && hitBus.ready;
    lastIdx    = modeR ? (CNTW'(numR) - CNTW'(1)) : CNTW'(NROWS_HCM - 1);
    isLast     = (index == lastIdx);
    // a stop arriving with the transfer counts as already seen
    finishNow  = xfer && (stopReq || stop || (isLast && !loopR));
    nextIdx    = isLast ? '0 : index + CNTW'(1);
    nextPass   = isLast ? passCnt + PASSW'(1) : passCnt;
    nextSsid   = modeR ? tbl[nextIdx[IDXBITS-1:0]] : nextIdx[SSIDBITS-1:0];
    firstSsid  = mode ? tbl[0] : '0;
    // lengths beyond the table would address nonexistent entries
    numClamp   = (numEntries > LENBITS'(TABLEDEPTH)) ? LENBITS'(TABLEDEPTH) : numEntries;
    emptyStart = mode && (numEntries == '0);
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = emptyStart ? FINISH : RUN;
      RUN:     if (finishNow) nextState = FINISH;
      FINISH:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    hitBus.newAddress = (state == RUN);
    busy              = (state == RUN);
    done              = (state == FINISH);
  end

  // Run context, item registers and sticky stop request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      modeR   <= 1'b0;
      loopR   <= 1'b0;
      numR    <= '0;
      index   <= '0;
      passCnt <= '0;
      stopReq <= 1'b0;
      ssidR   <= '1;
      hitR    <= '1;
    end else begin
      case (state)
        IDLE: if (start) begin
          modeR   <= mode;
          loopR   <= loopForever;
          numR    <= numClamp;
          index   <= '0;
          passCnt <= '0;
          stopReq <= 1'b0;
          // an empty table emits nothing, so the last item stays visible
          if (!emptyStart) begin
            ssidR <= firstSsid;
            hitR  <= {PASSW'(0), firstSsid};
          end
        end
        RUN: begin
          if (stop) stopReq <= 1'b1;
          // on the finishing transfer the item registers hold their value
          if (xfer && !finishNow) begin
            index   <= nextIdx;
            passCnt <= nextPass;
            ssidR   <= nextSsid;
            hitR    <= {nextPass, nextSsid};
          end
        end
        default: ;
      endcase
    end
  end

  assign hitBus.SSID    = ssidR;
  assign hitBus.hitInfo = hitR;

endmodule

// File: tb/tb_ssid_hit_generator.sv
// Directed bench for ssid_hit_generator: sweep, table playback with
// backpressure, looping with stop, empty table, ignored start/writes in RUN,
// and asynchronous reset mid-run.
module tb_ssid_hit_generator;

  localparam int SSIDBITS   = 8;
  localparam int NCOLS_HLM  = 16;
  localparam int NROWS_HCM  = 256;
  localparam int TABLEDEPTH = 32;
  localparam int IDXBITS    = 5;
  localparam int LENBITS    = 6;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                start, stop, mode, loopForever;
  logic [LENBITS-1:0]  numEntries;
  logic                tableWrEn;
  logic [IDXBITS-1:0]  tableWrAddr;
  logic [SSIDBITS-1:0] tableWrData;
  logic                busy, done;

  int testCnt = 0;
  int failCnt = 0;

  ssid_hit_generator_if #(.SSIDBITS(SSIDBITS), .NCOLS_HLM(NCOLS_HLM)) hitBus ();

  ssid_hit_generator #(
    .SSIDBITS(SSIDBITS), .NCOLS_HLM(NCOLS_HLM), .NROWS_HCM(NROWS_HCM),
    .TABLEDEPTH(TABLEDEPTH), .IDXBITS(IDXBITS), .LENBITS(LENBITS)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .mode(mode),
    .loopForever(loopForever), .numEntries(numEntries), .tableWrEn(tableWrEn),
    .tableWrAddr(tableWrAddr), .tableWrData(tableWrData), .busy(busy),
    .done(done), .hitBus(hitBus.master)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // inputs change and outputs are sampled at the falling edge
  task automatic step();
    @(negedge clock);
  endtask

  logic [7:0] tblVals [4];
  int k;

  initial begin
    tblVals[0] = 8'h00; tblVals[1] = 8'h33; tblVals[2] = 8'hC7; tblVals[3] = 8'h84;
    reset_n = 1'b0; start = 0; stop = 0; mode = 0; loopForever = 0; numEntries = '0;
    tableWrEn = 0; tableWrAddr = '0; tableWrData = '0; hitBus.ready = 1'b0;

    // reset state
    step();
    chk("rst SSID", 32'(hitBus.SSID), 32'hFF);
    chk("rst hitInfo", 32'(hitBus.hitInfo), 32'hFFFF);
    chk("rst newAddress", 32'(hitBus.newAddress), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    reset_n = 1'b1;
    step();

    // full sweep, one item per clock
    start = 1; mode = 0; loopForever = 0; hitBus.ready = 1;
    step();
    start = 0;
    for (int i = 0; i < 256; i++) begin
      chk("sweep newAddress", 32'(hitBus.newAddress), 1);
      chk("sweep busy", 32'(busy), 1);
      chk("sweep hitInfo", 32'(hitBus.hitInfo), 32'(i));
      step();
    end
    chk("sweep done", 32'(done), 1);
    chk("sweep busy end", 32'(busy), 0);
    chk("sweep newAddress end", 32'(hitBus.newAddress), 0);
    chk("sweep hold", 32'(hitBus.hitInfo), 32'h00FF);
    step();
    chk("sweep done 1cyc", 32'(done), 0);

    // load table
    for (int i = 0; i < 4; i++) begin
      tableWrEn = 1; tableWrAddr = 5'(i); tableWrData = tblVals[i];
      step();
    end
    tableWrEn = 0;

    // table playback with ready toggling 1,0,1,0
    start = 1; mode = 1; numEntries = 6'd4; loopForever = 0;
    step();
    start = 0;
    k = 0;
    for (int cyc = 0; cyc < 20 && !done && k < 4; cyc++) begin
      chk("tbl newAddress", 32'(hitBus.newAddress), 1);
      chk("tbl hitInfo", 32'(hitBus.hitInfo), 32'(tblVals[k]));
      hitBus.ready = (cyc % 2 == 0);
      if (hitBus.ready) k++;
      step();
    end
    chk("tbl transfers", 32'(k), 4);
    chk("tbl done", 32'(done), 1);
    chk("tbl newAddress end", 32'(hitBus.newAddress), 0);
    hitBus.ready = 1;
    step();

    // looping playback of 3 entries, stop during pass 2 item 1
    start = 1; mode = 1; numEntries = 6'd3; loopForever = 1;
    step();
    start = 0;
    for (int i = 0; i < 8; i++) begin
      chk("loop newAddress", 32'(hitBus.newAddress), 1);
      chk("loop hitInfo", 32'(hitBus.hitInfo), {16'h0, 8'(i / 3), tblVals[i % 3]});
      if (i == 7) stop = 1;
      step();
      stop = 0;
    end
    chk("loop done", 32'(done), 1);
    chk("loop newAddress end", 32'(hitBus.newAddress), 0);
    chk("loop hold", 32'(hitBus.hitInfo), 32'h0233);
    step();
    chk("loop idle", 32'(busy), 0);

    // stop coinciding with the last-entry transfer
    start = 1; mode = 1; numEntries = 6'd3; loopForever = 1;
    step();
    start = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stoplast hitInfo", 32'(hitBus.hitInfo), 32'(tblVals[i]));
      if (i == 2) stop = 1;
      step();
      stop = 0;
    end
    chk("stoplast done", 32'(done), 1);
    chk("stoplast hold", 32'(hitBus.hitInfo), 32'h00C7);
    step();
    chk("stoplast done 1cyc", 32'(done), 0);

    // empty table
    start = 1; mode = 1; numEntries = 6'd0; loopForever = 0;
    step();
    start = 0;
    chk("empty newAddress", 32'(hitBus.newAddress), 0);
    chk("empty done", 32'(done), 1);
    chk("empty busy", 32'(busy), 0);
    step();
    chk("empty done 1cyc", 32'(done), 0);
    chk("empty newAddress 2", 32'(hitBus.newAddress), 0);

    // start and table write during RUN are ignored
    start = 1; mode = 1; numEntries = 6'd4; loopForever = 0;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("ign SSID", 32'(hitBus.SSID), 32'(tblVals[i]));
      if (i == 1) begin
        start = 1; tableWrEn = 1; tableWrAddr = 5'd2; tableWrData = 8'h55;
      end
      step();
      start = 0; tableWrEn = 0;
    end
    chk("ign done", 32'(done), 1);
    step();
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4; i++) begin
      chk("readback SSID", 32'(hitBus.SSID), 32'(tblVals[i]));
      step();
    end
    chk("readback done", 32'(done), 1);
    step();

    // asynchronous reset mid-sweep
    start = 1; mode = 0; loopForever = 0;
    step();
    start = 0;
    for (int i = 0; i < 64; i++) step();
    chk("mid SSID", 32'(hitBus.SSID), 32'h40);
    reset_n = 0;
    #1;
    chk("arst SSID", 32'(hitBus.SSID), 32'hFF);
    chk("arst hitInfo", 32'(hitBus.hitInfo), 32'hFFFF);
    chk("arst newAddress", 32'(hitBus.newAddress), 0);
    chk("arst busy", 32'(busy), 0);
    step();
    chk("arst no done", 32'(done), 0);
    reset_n = 1;
    step();
    chk("arst no done 2", 32'(done), 0);
    chk("arst idle", 32'(hitBus.newAddress), 0);

    // restart after reset, with backpressure, then stop
    hitBus.ready = 0; start = 1;
    step();
    start = 0;
    chk("restart newAddress", 32'(hitBus.newAddress), 1);
    chk("restart SSID", 32'(hitBus.SSID), 0);
    step();
    chk("restart held", 32'(hitBus.SSID), 0);
    hitBus.ready = 1;
    step();
    chk("restart next", 32'(hitBus.SSID), 1);
    stop = 1;
    step();
    stop = 0;
    chk("restart stop done", 32'(done), 1);
    chk("restart stop hold", 32'(hitBus.hitInfo), 32'h0001);
    step();

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/ssid_hit_generator.md
Name: ssid_hit_generator

Overview:
Parametrised source of SSID/hit words for driving the hit-list and hit-count memories in test and bring-up.
Two modes:
- Full sweep of SSID 0..NROWS_HCM-1.
- Playback of a runtime-loadable SSID table.
Output uses a valid/ready handshake with backpressure, and supports one-shot or continuous looping with a clean stop.
Sits between the stimulus/control logic and the memory write path, replacing the fixed-list generator.

Parameters:
SSIDBITS, 8, width of one SSID.
NCOLS_HLM, 16, width of hitInfo. Must be > SSIDBITS.
NROWS_HCM, 256, sweep length. Sweep covers 0..NROWS_HCM-1. Must be <= 2^SSIDBITS.
TABLEDEPTH, 32, entries in the playback table.
IDXBITS, clog2(TABLEDEPTH), table address width.
LENBITS, clog2(TABLEDEPTH+1), table length width.

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  begin a run. Sampled only in IDLE.
stop  in  1  end a looping run after the current item is accepted
mode  in  1  0 = sweep, 1 = table playback. Latched at start.
loopForever  in  1  1 = wrap to first entry and continue. Latched at start.
numEntries  in  LENBITS  table entries used in mode 1. Latched at start.
tableWrEn  in  1  table write strobe
tableWrAddr  in  IDXBITS  table write address
tableWrData  in  SSIDBITS  table write data
ready  in  1  downstream accepts the current item
SSID  out  SSIDBITS  current SSID
hitInfo  out  NCOLS_HLM  upper bits = pass count, lower bits = SSID
newAddress  out  1  item valid
busy  out  1  high in RUN
done  out  1  one-cycle completion pulse

Behaviour:
- Reset (asynchronous, reset_n low):
  - SSID = all ones; hitInfo = all ones.
  - newAddress = 0; busy = 0; done = 0.
  - State = IDLE; index = 0; pass counter = 0.
  - Table contents are not reset.
- States: IDLE, RUN, FINISH.
- IDLE:
  - start=1 latches mode, loopForever and numEntries, clears index and pass counter, and enters RUN.
  - newAddress and the first item are presented the cycle after start is sampled (latency 1).
  - If mode=1 and numEntries=0: go straight to FINISH. No item is emitted.
- RUN:
  - newAddress=1 continuously. SSID/hitInfo stay stable while newAddress=1 and ready=0.
  - Transfer occurs on any cycle with newAddress=1 and ready=1. The next item appears the following cycle, so ready held high gives one item per clock.
  - Item value: mode 0 gives SSID = index. Mode 1 gives SSID = table[index].
  - hitInfo[SSIDBITS-1:0] = SSID. hitInfo[NCOLS_HLM-1:SSIDBITS] = pass counter, truncated to that width and wrapping modulo its width.
  - Last entry (index = NROWS_HCM-1 in mode 0, numEntries-1 in mode 1), on transfer:
    - loopForever=0, or stop seen: go to FINISH.
    - Otherwise: index = 0 and pass counter +1.
  - stop is registered as a sticky request. The in-flight item is never dropped. On the next transfer the block goes to FINISH, even if that is not the last entry.
  - start is ignored in RUN.
- FINISH: one cycle. newAddress=0, done=1, busy=0. SSID/hitInfo hold their last values. Next state is IDLE.
- busy=1 exactly while in RUN.
- Table writes:
  - Accepted only when not in RUN. Ignored while busy.
  - Write-first: a write in IDLE is visible to a start in the following cycle.
- Reads of the table are registered, or prefetched one entry ahead, so that back-to-back issue holds at one item per clock.
- Simultaneous stop and last-entry transfer: FINISH once; the pass counter does not increment.
- Reset mid-run: outputs immediately return to their reset values. No done pulse.

Test Plan:
- Sweep, NROWS_HCM=256, ready=1, loopForever=0, start at cycle 0 -> newAddress high in cycles 1..256 with SSID 0..255 and hitInfo=0x00SS. done pulses in cycle 257. busy low from cycle 257.
- Table mode: write entries {0x00,0x33,0xC7,0x84}, numEntries=4, ready toggling 1,0,1,0 -> exactly 4 transfers of SSIDs 00,33,C7,84 in order. Values stable during ready=0 cycles.
- Table mode, loopForever=1, numEntries=3, ready=1; assert stop while the 2nd item of pass 2 is presented -> stream 3 items with hitInfo upper=0, then 3 with upper=1, then items 0,1 of pass 2 (upper=2). done follows the transfer of the item presented when stop was asserted.
- numEntries=0 in mode 1 -> no newAddress. done pulses one cycle after start.
- start asserted during RUN, and tableWrEn during RUN -> ignored. The stream is unchanged and a post-run readback stream matches the original table.
- reset_n pulsed low mid-sweep at SSID 0x40 -> SSID=0xFF, hitInfo=0xFFFF, newAddress=0 asynchronously. No done. A new start resumes from SSID 0.
